lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the core's execute stage and a data-memory port with a req/gnt/rvalid handshake.
- Takes the decoded memory instruction (ALU address, rs2 data, funct3, store flag) and stalls the core until the access completes.
- Drives word-aligned memory requests with byte enables, then returns sign- or zero-extended load data.
- Flags misaligned, illegal-funct3 and timed-out accesses instead of issuing them.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before a timeout fault; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  synchronous, active-high reset
- i_req  in  1  memory instruction present in execute; held until o_done
- i_we  in  1  1 = store, 0 = load
- i_funct3  in  3  access size/sign (RV32I load/store encoding)
- i_addr  in  32  effective byte address from ALU
- i_wdata  in  32  rs2 store data
- o_stall  out  1  freeze PC and pipeline register
- o_done  out  1  one-cycle completion pulse; load writeback valid this cycle
- o_rdata  out  32  extended load data, valid with o_done
- o_exc  out  1  exception pulse, coincident with o_done or issued in IDLE
- o_exc_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
- o_mem_req  out  1  memory request (registered)
- o_mem_we  out  1  memory write
- o_mem_addr  out  32  {addr[31:2],2'b00}
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_gnt  in  1  request accepted this cycle
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  32  read data word

Behaviour:
- One clock; reset is synchronous, active-high on i_reset. Reset forces state IDLE; every registered output goes to 0 and the counter to 0. Reset mid-transaction abandons the access: o_mem_req is 0 the cycle after reset. A stale rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, i_req=1:
  - Checks: misaligned = (LH/LHU/SH & addr[0]) | (LW/SW & addr[1:0]!=0). Illegal = load funct3 in {011,110,111}, or store funct3 > 010. Illegal is checked first.
  - If either check fails: o_exc=1 and o_done=1 in the same cycle (combinational), cause set accordingly, o_stall=0, no memory access, stay in IDLE.
  - Otherwise: o_stall=1 combinationally; register addr, funct3, we, be, wdata; go to REQ.
- REQ:
  - o_mem_req=1, with addr/we/be/wdata held stable until gnt.
  - Store + gnt → DONE.
  - Load + gnt + rvalid in the same cycle → capture rdata → DONE.
  - Load + gnt only → WAIT.
- WAIT: o_mem_req=0; on rvalid, capture rdata → DONE.
- DONE: o_stall=0, o_done=1 for one cycle, then IDLE. In IDLE the next cycle, i_req belongs to the next instruction.
- o_stall is 1 in REQ and WAIT, and in IDLE when an aligned, legal i_req is accepted.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: → DONE with o_exc=1, cause 11, o_rdata=0, o_mem_req dropped.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<addr[1:0].
  - SW: 4'b1111.
  - Loads: same pattern by size (informational only).
- Store data: SB replicates the byte {4{wdata[7:0]}}; SH replicates the halfword {2{wdata[15:0]}}; SW passes through.
- Load data:
  - Shift rdata right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Latency:
  - Load with gnt at cycle 1 and rvalid at cycle 2: o_done at cycle 3 (3 stall cycles).
  - Store with gnt at cycle 1: o_done at cycle 2.
- o_rdata holds its value after DONE until the next load capture. It is 0 for stores and exceptions.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams LB/LH/LW/LBU/LHU and SB/SH/SW;
  - the state enum {IDLE, REQ, WAIT, DONE};
  - cause codes CAUSE_NONE/MISALIGN/ILLEGAL/TIMEOUT.
- One combinational sub-module, lsu_align: produces be and replicated wdata from (funct3, addr[1:0], wdata), and extracted/extended rdata from (funct3, addr[1:0], rdata). The FSM and counter stay in lsu_ctrl.

Test Plan:
- LW addr 0x100; gnt at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF → mem_addr 0x100, be 1111, o_done at cycle 3, o_rdata 0xDEADBEEF, o_stall high for cycles 0–2.
- LB addr 0x203, rdata 0x80AABBCC → be 1000, o_rdata 0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x202 → 0x000080AA.
- SB addr 0x301, wdata 0x12345678, gnt delayed 3 cycles → mem_addr 0x300, be 0010, wdata 0x78787878, request held stable 4 cycles, o_done 1 cycle after gnt.
- LW addr 0x102 → o_exc=1, cause 01, o_done same cycle, no o_mem_req. Load with funct3 011 → cause 10.
- TIMEOUT_CYCLES=4, gnt never asserted → o_exc with cause 11 and o_done 4 cycles after entering REQ; o_mem_req low afterwards.
- i_reset asserted while in WAIT, then rvalid pulses → next cycle in IDLE with all outputs 0; rvalid ignored; following LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: funct3 codes, FSM states,
// exception cause codes and the access legality check.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Illegal funct3 takes priority over misalignment.
  function automatic logic [1:0] access_check(input logic we, input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic illegal;
    logic misaligned;
    illegal    = we ? (f3 > SW) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    if (illegal)
      return CAUSE_ILLEGAL;
    else if (misaligned)
      return CAUSE_MISALIGN;
    else
      return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port between the load/store sequencer (master) and memory (slave).
interface lsu_ctrl_if;
  // req/gnt: the master raises req with we/addr/be/wdata and holds all of them
  // stable until the cycle gnt is high; that cycle transfers the request.
  // rvalid marks rdata as the read word for the granted load, in the grant
  // cycle or any later cycle; there is no back-pressure on the read return.
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_align.sv
// Lane steering: byte enables and replicated store data on the way out,
// shifted and sign/zero-extended load data on the way back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rdata_ext = 32'h0;
    case (funct3)
      LB:      rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      LH:      rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      LW:      rdata_ext = shifted;
      LBU:     rdata_ext = {24'h0, shifted[7:0]};
      LHU:     rdata_ext = {16'h0, shifted[15:0]};
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store sequencer: stalls the core while one access runs on
// the req/gnt/rvalid memory port; faults are reported without a memory access.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_exc,
  output logic [1:0]  o_exc_cause,
  lsu_ctrl_if.master  mem,
  output lsu_state_t  o_dbg_state
);

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t state;

  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic             we_q;
  logic             mem_req_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q;
  logic [31:0]      rdata_q;
  logic             exc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]  check_cause;
  logic        idle_fault;
  logic        accept;
  logic        timeout_hit;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign check_cause = access_check(i_we, i_funct3, i_addr[1:0]);
  assign idle_fault  = (state == IDLE) && i_req && (check_cause != CAUSE_NONE);
  assign accept      = (state == IDLE) && i_req && (check_cause == CAUSE_NONE);
  // Last cycle allowed in REQ+WAIT is when the counter reads TIMEOUT_CYCLES-1.
  assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

  // One aligner serves both directions: live inputs while accepting in IDLE,
  // the captured access while a load is waiting for its data.
  assign al_funct3  = (state == IDLE) ? i_funct3    : funct3_q;
  assign al_addr_lo = (state == IDLE) ? i_addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .wdata     (i_wdata),
    .rdata     (mem.rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      we_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      exc_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= REQ;
            mem_req_q   <= 1'b1;
            we_q        <= i_we;
            funct3_q    <= i_funct3;
            addr_lo_q   <= i_addr[1:0];
            mem_addr_q  <= {i_addr[31:2], 2'b00};
            mem_be_q    <= al_be;
            mem_wdata_q <= al_wdata;
            rdata_q     <= 32'h0;
            exc_q       <= 1'b0;
            cnt_q       <= '0;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem.gnt) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              state <= DONE;
            end else if (mem.rvalid) begin
              rdata_q <= al_rdata;
              state   <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            exc_q     <= 1'b1;
            rdata_q   <= 32'h0;
            state     <= DONE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem.rvalid) begin
            rdata_q <= al_rdata;
            state   <= DONE;
          end else if (timeout_hit) begin
            exc_q   <= 1'b1;
            rdata_q <= 32'h0;
            state   <= DONE;
          end
        end
        DONE: begin
          exc_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_stall     = (state == REQ) || (state == WAIT) || accept;
  assign o_done      = (state == DONE) || idle_fault;
  assign o_exc       = ((state == DONE) && exc_q) || idle_fault;
  assign o_exc_cause = idle_fault ? check_cause :
                       ((state == DONE) && exc_q) ? CAUSE_TIMEOUT : CAUSE_NONE;
  assign o_rdata     = idle_fault ? 32'h0 : rdata_q;

  assign mem.req   = mem_req_q;
  assign mem.we    = we_q;
  assign mem.addr  = mem_addr_q;
  assign mem.be    = mem_be_q;
  assign mem.wdata = mem_wdata_q;

  assign o_dbg_state = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized accesses checked
// against a byte-lane reference model of the load/store rules.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req;
  logic        req1;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        stall, done, exc;
  logic [31:0] rdata;
  logic [1:0]  cause;
  lsu_state_t  dbg;

  logic        stall1, done1, exc1;
  logic [31:0] rdata1;
  logic [1:0]  cause1;
  lsu_state_t  dbg1;

  lsu_ctrl_if m0();
  lsu_ctrl_if m1();

  lsu_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_stall(stall), .o_done(done),
    .o_rdata(rdata), .o_exc(exc), .o_exc_cause(cause), .mem(m0.master),
    .o_dbg_state(dbg)
  );

  lsu_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
    .i_clk(clk), .i_reset(rst), .i_req(req1), .i_we(we), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_stall(stall1), .o_done(done1),
    .o_rdata(rdata1), .o_exc(exc1), .o_exc_cause(cause1), .mem(m1.master),
    .o_dbg_state(dbg1)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic [1:0]  obs_cause;

  // ---------------- reference model ----------------
  function automatic logic [1:0] m_cause(input logic w, input logic [2:0] fn, input logic [31:0] a);
    int sz;
    sz = 1 << fn[1:0];
    if (w ? (fn > 3'd2) : (fn inside {3'd3, 3'd6, 3'd7})) return 2'b10;
    if ((a % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] fn, input logic [31:0] a);
    int sz;
    sz = 1 << fn[1:0];
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] fn, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = 1 << fn[1:0];
    r  = 32'h0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(wd >> (8 * (i % sz)));
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int sz;
    sz = 1 << fn[1:0];
    v  = rd >> (8 * (a % 4));
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if (!fn[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver ----------------
  // gd: cycles of req before gnt; rdl: cycles from gnt to rvalid (loads).
  task automatic run_access(input logic w, input logic [2:0] fn, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gd, input int rdl, input string tag);
    logic [1:0]  ec;
    logic [31:0] erd;
    int gc, dc;
    ec = m_cause(w, fn, a);
    @(negedge clk);
    req = 1'b1; we = w; f3 = fn; addr = a; wdata = wd;
    m0.gnt = 1'b0; m0.rvalid = 1'b0;
    #1;
    if (ec != 2'b00) begin
      obs_cause = cause;
      total++;
      if (done !== 1'b1 || exc !== 1'b1 || cause !== ec || stall !== 1'b0 ||
          m0.req !== 1'b0 || rdata !== 32'h0) begin
        bad++;
        $display("FAIL %s fault: done=%b exc=%b cause=%b stall=%b mreq=%b rdata=%h, want 1 1 %b 0 0 0",
                 tag, done, exc, cause, stall, m0.req, rdata, ec);
      end
      @(posedge clk); #1;
      req = 1'b0;
      total++;
      if (m0.req !== 1'b0 || dbg !== IDLE) begin
        bad++;
        $display("FAIL %s fault_idle: mreq=%b state=%0d, want 0 IDLE", tag, m0.req, dbg);
      end
      return;
    end
    total++;
    if (stall !== 1'b1 || done !== 1'b0 || exc !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: stall=%b done=%b exc=%b, want 1 0 0", tag, stall, done, exc);
    end
    exp_q.push_back(w ? 32'h0 : m_rdata(fn, a, rd));
    gc = 1 + gd;
    dc = w ? gc + 1 : gc + rdl + 1;
    for (int c = 1; c < dc; c++) begin
      @(negedge clk);
      m0.gnt    = (c == gc);
      m0.rvalid = !w && (c == gc + rdl);
      m0.rdata  = (c == gc + rdl) ? rd : $urandom;
      #1;
      total++;
      if (stall !== 1'b1 || done !== 1'b0 || m0.req !== (c <= gc)) begin
        bad++;
        $display("FAIL %s busy c=%0d: stall=%b done=%b mreq=%b, want 1 0 %b",
                 tag, c, stall, done, m0.req, (c <= gc));
      end
      if (c <= gc) begin
        if (c == 1) begin
          obs_addr = m0.addr; obs_be = m0.be; obs_wdata = m0.wdata;
        end
        total++;
        if (m0.addr !== {a[31:2], 2'b00} || m0.be !== m_be(fn, a) || m0.we !== w ||
            (w && m0.wdata !== m_wdata(fn, wd))) begin
          bad++;
          $display("FAIL %s bus c=%0d: addr=%h be=%b we=%b wdata=%h, want %h %b %b %h",
                   tag, c, m0.addr, m0.be, m0.we, m0.wdata, {a[31:2], 2'b00},
                   m_be(fn, a), w, m_wdata(fn, wd));
        end
      end
    end
    @(negedge clk);
    m0.gnt = 1'b0; m0.rvalid = 1'b0;
    #1;
    erd = exp_q.pop_front();
    obs_rdata = rdata;
    total++;
    if (done !== 1'b1 || stall !== 1'b0 || exc !== 1'b0 || cause !== 2'b00 ||
        rdata !== erd || m0.req !== 1'b0) begin
      bad++;
      $display("FAIL %s done: done=%b stall=%b exc=%b cause=%b rdata=%h mreq=%b, want 1 0 0 00 %h 0",
               tag, done, stall, exc, cause, rdata, m0.req, erd);
    end
    req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (stall !== 0 || done !== 0 || exc !== 0 || cause !== 0 || rdata !== 0 ||
        m0.req !== 0 || m0.we !== 0 || m0.addr !== 0 || m0.be !== 0 ||
        m0.wdata !== 0 || dbg !== IDLE) begin
      bad++;
      $display("FAIL reset: stall=%b done=%b exc=%b req=%b addr=%h be=%b state=%0d, want all 0 IDLE",
               stall, done, exc, m0.req, m0.addr, m0.be, dbg);
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_access(1'b0, LW, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, "lw");
    total++;
    if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lw_values: addr=%h be=%b rdata=%h, want 00000100 1111 deadbeef",
               obs_addr, obs_be, obs_rdata);
    end
  endtask

  task automatic test_load_ext();
    run_access(1'b0, LB, 32'h203, 32'h0, 32'h80AABBCC, 1, 0, "lb");
    total++;
    if (obs_be !== 4'b1000 || obs_rdata !== 32'hFFFFFF80) begin
      bad++;
      $display("FAIL lb_values: be=%b rdata=%h, want 1000 ffffff80", obs_be, obs_rdata);
    end
    run_access(1'b0, LBU, 32'h203, 32'h0, 32'h80AABBCC, 0, 2, "lbu");
    total++;
    if (obs_rdata !== 32'h00000080) begin
      bad++;
      $display("FAIL lbu_value: rdata=%h, want 00000080", obs_rdata);
    end
    run_access(1'b0, LHU, 32'h202, 32'h0, 32'h80AABBCC, 0, 0, "lhu");
    total++;
    if (obs_rdata !== 32'h000080AA) begin
      bad++;
      $display("FAIL lhu_value: rdata=%h, want 000080aa", obs_rdata);
    end
    // Load data must hold through idle cycles until the next capture.
    @(negedge clk); #1;
    total++;
    if (rdata !== 32'h000080AA || done !== 1'b0) begin
      bad++;
      $display("FAIL rdata_hold: rdata=%h done=%b, want 000080aa 0", rdata, done);
    end
  endtask

  task automatic test_sb();
    run_access(1'b1, SB, 32'h301, 32'h12345678, 32'h0, 3, 0, "sb");
    total++;
    if (obs_addr !== 32'h300 || obs_be !== 4'b0010 || obs_wdata !== 32'h78787878 ||
        obs_rdata !== 32'h0) begin
      bad++;
      $display("FAIL sb_values: addr=%h be=%b wdata=%h rdata=%h, want 00000300 0010 78787878 0",
               obs_addr, obs_be, obs_wdata, obs_rdata);
    end
  endtask

  task automatic test_exc();
    run_access(1'b0, LW, 32'h102, 32'h0, 32'h0, 0, 0, "lw_mis");
    total++;
    if (obs_cause !== 2'b01) begin
      bad++;
      $display("FAIL misalign_cause: cause=%b, want 01", obs_cause);
    end
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, "ld_ill");
    total++;
    if (obs_cause !== 2'b10) begin
      bad++;
      $display("FAIL illegal_cause: cause=%b, want 10", obs_cause);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    req1 = 1'b1; we = 1'b0; f3 = LW; addr = 32'h80; wdata = 32'h0;
    #1;
    total++;
    if (stall1 !== 1'b1) begin
      bad++;
      $display("FAIL to_accept: stall=%b, want 1", stall1);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      total++;
      if (m1.req !== 1'b1 || stall1 !== 1'b1 || done1 !== 1'b0) begin
        bad++;
        $display("FAIL to_wait c=%0d: mreq=%b stall=%b done=%b, want 1 1 0", c, m1.req, stall1, done1);
      end
    end
    @(negedge clk); #1;
    total++;
    if (done1 !== 1'b1 || exc1 !== 1'b1 || cause1 !== 2'b11 || rdata1 !== 32'h0 ||
        m1.req !== 1'b0 || stall1 !== 1'b0) begin
      bad++;
      $display("FAIL to_fire: done=%b exc=%b cause=%b rdata=%h mreq=%b stall=%b, want 1 1 11 0 0 0",
               done1, exc1, cause1, rdata1, m1.req, stall1);
    end
    req1 = 1'b0;
    @(negedge clk); #1;
    total++;
    if (m1.req !== 1'b0 || done1 !== 1'b0 || exc1 !== 1'b0 || dbg1 !== IDLE) begin
      bad++;
      $display("FAIL to_after: mreq=%b done=%b exc=%b state=%0d, want 0 0 0 IDLE",
               m1.req, done1, exc1, dbg1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; we = 1'b0; f3 = LW; addr = 32'h40;
    @(negedge clk);
    m0.gnt = 1'b1;
    @(negedge clk);
    m0.gnt = 1'b0; rst = 1'b1; req = 1'b0;
    #1;
    total++;
    if (dbg !== WAIT || m0.req !== 1'b0) begin
      bad++;
      $display("FAIL mid_wait: state=%0d mreq=%b, want WAIT 0", dbg, m0.req);
    end
    @(negedge clk);
    rst = 1'b0; m0.rvalid = 1'b1; m0.rdata = 32'hFFFFFFFF;
    #1;
    total++;
    if (dbg !== IDLE || m0.req !== 0 || stall !== 0 || done !== 0 || exc !== 0 ||
        rdata !== 0 || m0.addr !== 0 || m0.be !== 0) begin
      bad++;
      $display("FAIL mid_reset: state=%0d mreq=%b stall=%b done=%b rdata=%h addr=%h be=%b, want IDLE all 0",
               dbg, m0.req, stall, done, rdata, m0.addr, m0.be);
    end
    @(negedge clk);
    m0.rvalid = 1'b0;
    #1;
    total++;
    if (dbg !== IDLE || done !== 0 || rdata !== 0 || stall !== 0) begin
      bad++;
      $display("FAIL stale_rvalid: state=%0d done=%b rdata=%h stall=%b, want IDLE 0 0 0",
               dbg, done, rdata, stall);
    end
    run_access(1'b0, LW, 32'h44, 32'h0, 32'hCAFEF00D, 0, 1, "lw_after_rst");
    total++;
    if (obs_rdata !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL post_reset_lw: rdata=%h, want cafef00d", obs_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic        w;
    logic [2:0]  fn;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      w  = 1'($urandom_range(0, 1));
      fn = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << fn[1:0]) - 32'd1);
      run_access(w, fn, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; req = 1'b0; req1 = 1'b0; we = 1'b0; f3 = 3'b000;
    addr = 32'h0; wdata = 32'h0;
    m0.gnt = 1'b0; m0.rvalid = 1'b0; m0.rdata = 32'h0;
    m1.gnt = 1'b0; m1.rvalid = 1'b0; m1.rdata = 32'h0;
    test_reset();
    test_lw();
    test_load_ext();
    test_sb();
    test_exc();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
